// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Every output is registered; tx_serial is computed from the next state so the line never glitches.
module uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_serial
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             par_q, par_d;
   logic             serial_d, busy_d, done_d;
   logic             bit_end;

   assign bit_end = (cnt_q == CNT_MAX);

   // State register, including the registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         tx_serial <= 1'b1;
         tx_busy   <= 1'b0;
         tx_done   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         tx_serial <= serial_d;
         tx_busy   <= busy_d;
         tx_done   <= done_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      par_d   = par_q;
      if (state_q != IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
      end
      case (state_q)
         IDLE: begin
            if (tx_start) begin
               state_d = START;
               cnt_d   = '0;
               idx_d   = '0;
               shift_d = tx_data;
               // Parity is fixed at capture time since the shift register drains during DATA.
               par_d   = (^tx_data) ^ (PARITY_ODD != 0);
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               idx_d   = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (idx_q == 3'd7) begin
                  state_d = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         PARITY: begin
            if (bit_end) state_d = STOP;
         end
         STOP: begin
            if (bit_end) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: values the registered outputs take in the next cycle.
   always_comb begin
      serial_d = 1'b1;
      busy_d   = (state_d != IDLE);
      done_d   = (state_q == STOP) && bit_end;
      case (state_d)
         IDLE:    serial_d = 1'b1;
         START:   serial_d = 1'b0;
         DATA:    serial_d = shift_d[0];
         PARITY:  serial_d = par_d;
         STOP:    serial_d = 1'b1;
         default: serial_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations share one stimulus stream and are compared every cycle
// against a frame-level waveform model plus per-scenario busy/done totals.
module tb_uart_tx;

   logic       clk;
   logic       rst;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [3:0] busy;
   logic [3:0] done;
   logic [3:0] ser;

   int cpb [4] = '{4, 4, 4, 2};
   bit pe  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
   bit po  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

   logic exp_q [4][$];
   bit   done_exp [4];
   int   busy_cnt [4];
   int   done_cnt [4];
   int   n_checks = 0;
   int   n_errors = 0;

   uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
      .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
      .tx_busy(busy[0]), .tx_done(done[0]), .tx_serial(ser[0]));
   uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_par_even (
      .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
      .tx_busy(busy[1]), .tx_done(done[1]), .tx_serial(ser[1]));
   uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_par_odd (
      .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
      .tx_busy(busy[2]), .tx_done(done[2]), .tx_serial(ser[2]));
   uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(0), .PARITY_ODD(0)) u_fast (
      .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
      .tx_busy(busy[3]), .tx_done(done[3]), .tx_serial(ser[3]));

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected line for one frame: each bit of the frame held for cpb samples.
   task automatic push_frame(input int i, input logic [7:0] d);
      logic [10:0] bits;
      int nb;
      bits = '0;
      bits[0] = 1'b0;
      for (int b = 0; b < 8; b++) bits[b+1] = d[b];
      nb = 9;
      if (pe[i]) begin
         bits[nb] = (^d) ^ po[i];
         nb++;
      end
      bits[nb] = 1'b1;
      nb++;
      for (int b = 0; b < nb; b++) begin
         repeat (cpb[i]) exp_q[i].push_back(bits[b]);
      end
   endtask

   // A frame is pending while samples remain; a start is taken only with nothing pending.
   task automatic model_step(input int i);
      done_exp[i] = 1'b0;
      if (rst) begin
         exp_q[i].delete();
      end else if (exp_q[i].size() != 0) begin
         void'(exp_q[i].pop_front());
         if (exp_q[i].size() == 0) done_exp[i] = 1'b1;
      end else if (tx_start) begin
         push_frame(i, tx_data);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 4; i++) model_step(i);
      #1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("serial%0d", i), 32'(ser[i]),
               32'((exp_q[i].size() != 0) ? exp_q[i][0] : 1'b1));
         check($sformatf("busy%0d", i), 32'(busy[i]), 32'(exp_q[i].size() != 0));
         check($sformatf("done%0d", i), 32'(done[i]), 32'(done_exp[i]));
         if (busy[i] === 1'b1) busy_cnt[i]++;
         if (done[i] === 1'b1) done_cnt[i]++;
      end
   endtask

   task automatic run(input int n, input bit scramble);
      repeat (n) begin
         if (scramble) tx_data = 8'($urandom);
         tick();
      end
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 4; i++) begin
         busy_cnt[i] = 0;
         done_cnt[i] = 0;
      end
   endtask

   task automatic check_counts(input string tag, input int b0, input int b1, input int b2,
                               input int b3, input int d0, input int d1, input int d2, input int d3);
      int eb [4];
      int ed [4];
      eb = '{b0, b1, b2, b3};
      ed = '{d0, d1, d2, d3};
      for (int i = 0; i < 4; i++) begin
         if (eb[i] >= 0) check($sformatf("%s_busy%0d", tag, i), 32'(busy_cnt[i]), 32'(eb[i]));
         check($sformatf("%s_done%0d", tag, i), 32'(done_cnt[i]), 32'(ed[i]));
      end
   endtask

   task automatic send(input logic [7:0] d);
      tx_data  = d;
      tx_start = 1'b1;
      tick();
      tx_start = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      tx_start = 1'b1;
      tx_data  = 8'hAA;
      run(3, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rst_serial%0d", i), 32'(ser[i]), 32'd1);
         check($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
      end
      rst      = 1'b0;
      tx_start = 1'b0;
      run(3, 1'b0);

      // Single frame 0x41, data scrambled after capture.
      clear_counts();
      send(8'h41);
      run(59, 1'b1);
      check_counts("f41", 40, 44, 44, 20, 1, 1, 1, 1);

      // 0x07 exercises both parity polarities.
      clear_counts();
      send(8'h07);
      run(59, 1'b0);
      check_counts("f07", 40, 44, 44, 20, 1, 1, 1, 1);

      // Start pulse mid-frame must be ignored.
      run(5, 1'b0);
      clear_counts();
      send(8'hA5);
      run(10, 1'b0);
      send(8'h55);
      run(50, 1'b0);
      check_counts("ign", 40, 44, 44, 20, 1, 1, 1, 1);

      // Start held high: back-to-back frames with a one-cycle gap.
      run(5, 1'b0);
      clear_counts();
      tx_data  = 8'h30;
      tx_start = 1'b1;
      for (int k = 0; k < 100; k++) begin
         if (k == 20) tx_data = 8'h31;
         if (k == 50) tx_start = 1'b0;
         tick();
      end
      check_counts("hold", -1, -1, -1, -1, 2, 2, 2, 3);

      // Reset mid-frame aborts without a done pulse.
      run(5, 1'b0);
      clear_counts();
      send(8'hFF);
      run(16, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_serial", 32'(ser[0]), 32'd1);
      check("abort_busy", 32'(busy[0]), 32'd0);
      run(3, 1'b0);
      check_counts("abort", -1, -1, -1, -1, 0, 0, 0, 0);
      clear_counts();
      send(8'h00);
      run(59, 1'b0);
      check_counts("f00", 40, 44, 44, 20, 1, 1, 1, 1);

      // Random start pulses, data churn and occasional reset.
      for (int k = 0; k < 1500; k++) begin
         tx_start = ($urandom_range(0, 9) == 0);
         rst      = ($urandom_range(0, 299) == 0);
         tx_data  = 8'($urandom);
         tick();
      end
      rst      = 1'b0;
      tx_start = 1'b0;
      run(50, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
